motor_uart_rx: RTL and testbench



---
 rtl/motor_uart_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 83 ++++++++
 rtl/motor_uart_rx.sv | 120 ++++++++++++
 tb/tb_motor_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_uart_pkg.sv
// Shared constants and state encodings for the robot-base feedback receiver.
package motor_uart_pkg;

   localparam logic [7:0] HDR0_BYTE = 8'hAA;
   localparam logic [7:0] HDR1_BYTE = 8'h55;

   typedef enum logic [2:0] {
      P_HDR0,
      P_HDR1,
      P_LEN,
      P_PAYLOAD,
      P_CSUM
   } parser_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with input synchroniser; one-cycle byte_valid/frame_err strobes.
module uart_rx_byte
   import motor_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF   = CLKS_PER_BIT / 2;

   rx_state_t         state, state_n;
   logic [1:0]        sync_q;
   logic              rx_s, rx_prev;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic              tick;

   assign rx_s = sync_q[1];

   always_comb begin
      tick    = 1'b0;
      state_n = state;
      case (state)
         RX_IDLE:  if (rx_prev && !rx_s) state_n = RX_START;
         RX_START: begin
            tick = (baud_cnt == BAUD_W'(HALF - 1));
            if (tick) state_n = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
            if (tick && bit_cnt == 3'd7) state_n = RX_STOP;
         end
         RX_STOP: begin
            tick = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
            if (tick) state_n = RX_IDLE;
         end
         default: state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RX_IDLE;
         sync_q     <= '1;
         rx_prev    <= 1'b1;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         sync_q     <= {sync_q[0], rx};
         rx_prev    <= rx_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         baud_cnt   <= (state == RX_IDLE || tick) ? '0 : baud_cnt + BAUD_W'(1);
         if (state == RX_START) bit_cnt <= '0;
         if (state == RX_DATA && tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (state == RX_STOP && tick) begin
            if (rx_s) begin
               byte_data  <= shift;
               byte_valid <= 1'b1;
            end else begin
               frame_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/motor_uart_rx.sv
// Feedback packet receiver: AA 55 LEN payload CSUM framing, checksum check, status latch.
module motor_uart_rx
   import motor_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_CLKS = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_in,
   output logic [7:0] payload_data,
   output logic       payload_valid,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [7:0] status,
   output logic       status_valid
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);

   logic [7:0]       byte_data;
   logic             byte_valid, frame_err;
   parser_state_t    state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       acc, first_byte;
   logic             first_pending;
   logic [TMR_W-1:0] timer;
   logic             in_pkt, timeout, abort, ok_set, err_set;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (uart_in),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // Timer is loaded with 1 on each byte so pkt_err lands exactly TIMEOUT_CLKS after the strobe.
   always_comb begin
      in_pkt  = (state == P_LEN) || (state == P_PAYLOAD) || (state == P_CSUM);
      timeout = in_pkt && (timer == TMR_W'(TIMEOUT_CLKS - 1));
      abort   = in_pkt && (frame_err || timeout);
      state_n = state;
      ok_set  = 1'b0;
      err_set = abort;
      if (abort) begin
         state_n = P_HDR0;
      end else if (byte_valid) begin
         case (state)
            P_HDR0: if (byte_data == HDR0_BYTE) state_n = P_HDR1;
            P_HDR1: begin
               if (byte_data == HDR1_BYTE)      state_n = P_LEN;
               else if (byte_data != HDR0_BYTE) state_n = P_HDR0;
            end
            P_LEN: begin
               if (byte_data == 8'd0 || 32'(byte_data) > MAX_LEN) begin
                  err_set = 1'b1;
                  state_n = P_HDR0;
               end else begin
                  state_n = P_PAYLOAD;
               end
            end
            P_PAYLOAD: if (cnt == CNT_W'(1)) state_n = P_CSUM;
            P_CSUM: begin
               if (byte_data == acc) ok_set = 1'b1;
               else                  err_set = 1'b1;
               state_n = P_HDR0;
            end
            default: state_n = P_HDR0;
         endcase
      end
   end

   assign payload_valid = byte_valid && (state == P_PAYLOAD) && !abort;
   assign payload_data  = payload_valid ? byte_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= P_HDR0;
      else        state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         acc           <= '0;
         first_byte    <= '0;
         first_pending <= 1'b0;
         timer         <= '0;
         pkt_ok        <= 1'b0;
         pkt_err       <= 1'b0;
         status        <= '0;
         status_valid  <= 1'b0;
      end else begin
         pkt_ok  <= ok_set;
         pkt_err <= err_set;
         if (byte_valid)  timer <= TMR_W'(1);
         else if (in_pkt) timer <= timer + TMR_W'(1);
         else             timer <= '0;
         if (state == P_LEN && byte_valid && !abort) begin
            cnt           <= CNT_W'(byte_data);
            acc           <= byte_data;
            first_pending <= 1'b1;
         end
         if (payload_valid) begin
            cnt           <= cnt - CNT_W'(1);
            acc           <= acc ^ byte_data;
            first_pending <= 1'b0;
            if (first_pending) first_byte <= byte_data;
         end
         if (ok_set) begin
            status       <= first_byte;
            status_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_motor_uart_rx.sv
// Scoreboard bench for motor_uart_rx: directed packets, expected events queued, monitor compares.
module tb_motor_uart_rx;

   localparam int unsigned CPB     = 64;
   localparam int unsigned MAXL    = 16;
   localparam int unsigned TIMEOUT = 2000;

   localparam int EV_PAY = 0;
   localparam int EV_OK  = 1;
   localparam int EV_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      bit         chk_gap;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       uart_in;
   logic [7:0] payload_data;
   logic       payload_valid;
   logic       pkt_ok;
   logic       pkt_err;
   logic [7:0] status;
   logic       status_valid;

   int    checks = 0;
   int    errors = 0;
   longint cyc = 0;
   longint last_pv_cyc = 0;
   ev_t   exp_q[$];

   motor_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .MAX_LEN      (MAXL),
      .TIMEOUT_CLKS (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .uart_in       (uart_in),
      .payload_data  (payload_data),
      .payload_valid (payload_valid),
      .pkt_ok        (pkt_ok),
      .pkt_err       (pkt_err),
      .status        (status),
      .status_valid  (status_valid)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic monitor_event(input int kind, input logic [7:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d data %0h expected none", kind, data);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_PAY && e.data !== data)) begin
         errors++;
         $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                  kind, data, e.kind, e.data);
      end
      if (e.chk_gap) begin
         checks++;
         if (cyc - last_pv_cyc != longint'(TIMEOUT)) begin
            errors++;
            $display("FAIL timeout_gap: got %0d expected %0d", cyc - last_pv_cyc, TIMEOUT);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (payload_valid) begin
            monitor_event(EV_PAY, payload_data);
            last_pv_cyc = cyc;
         end
         if (pkt_ok)  monitor_event(EV_OK, 8'h00);
         if (pkt_err) monitor_event(EV_ERR, 8'h00);
      end
   end

   task automatic expect_ev(input int kind, input logic [7:0] data, input bit gap = 1'b0);
      ev_t e;
      e.kind    = kind;
      e.data    = data;
      e.chk_gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
      uart_in = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_in = b[i];
         repeat (CPB) @(posedge clk);
      end
      uart_in = good_stop;
      repeat (CPB) @(posedge clk);
      uart_in = 1'b1;
      if (!good_stop) repeat (CPB) @(posedge clk);
   endtask

   task automatic send_seq(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i]);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending events expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      uart_in = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_val("rst_payload_data", payload_data, 8'h00);
      check_val("rst_strobes", {5'b0, payload_valid, pkt_ok, pkt_err}, 8'h00);
      check_val("rst_status", status, 8'h00);
      check_val("rst_status_valid", {7'b0, status_valid}, 8'h00);
      rst_n = 1'b1;
      repeat (2 * CPB) @(posedge clk);

      // 1: good packet
      expect_ev(EV_PAY, 8'h05); expect_ev(EV_PAY, 8'h10); expect_ev(EV_OK, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h02, 8'h05, 8'h10, 8'h17});
      drain("s1");
      check_val("s1_status", status, 8'h05);
      check_val("s1_status_valid", {7'b0, status_valid}, 8'h01);

      // 2: bad checksum, status held
      expect_ev(EV_PAY, 8'h05); expect_ev(EV_PAY, 8'h10); expect_ev(EV_ERR, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h02, 8'h05, 8'h10, 8'h18});
      drain("s2");
      check_val("s2_status", status, 8'h05);

      // 3: garbage and repeated header byte
      expect_ev(EV_PAY, 8'h07); expect_ev(EV_OK, 8'h00);
      send_seq('{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h07, 8'h06});
      drain("s3");
      check_val("s3_status", status, 8'h07);

      // 4: LEN 0 and LEN 17 rejected, then good packet
      expect_ev(EV_ERR, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h00});
      expect_ev(EV_ERR, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h11});
      expect_ev(EV_PAY, 8'h20); expect_ev(EV_OK, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h01, 8'h20, 8'h21});
      drain("s4");
      check_val("s4_status", status, 8'h20);

      // 5: inter-byte timeout, then low stop bit mid-payload
      expect_ev(EV_PAY, 8'h01); expect_ev(EV_ERR, 8'h00, 1'b1);
      send_seq('{8'hAA, 8'h55, 8'h03, 8'h01});
      repeat (TIMEOUT + 200) @(posedge clk);
      drain("s5a");
      expect_ev(EV_PAY, 8'h01); expect_ev(EV_ERR, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h03, 8'h01});
      send_byte(8'h02, 1'b0);
      drain("s5b");
      check_val("s5_status", status, 8'h20);

      // 6a: short glitch produces nothing, line still usable
      uart_in = 1'b0;
      repeat (20) @(posedge clk);
      uart_in = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      expect_ev(EV_PAY, 8'h42); expect_ev(EV_OK, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h01, 8'h42, 8'h43});
      drain("s6a");
      check_val("s6a_status", status, 8'h42);

      // 6b: reset in the middle of a payload byte
      expect_ev(EV_PAY, 8'h0A);
      send_seq('{8'hAA, 8'h55, 8'h02, 8'h0A});
      drain("s6b_pre");
      uart_in = 1'b0;
      repeat (3 * CPB) @(posedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("s6b_rst_outputs", {5'b0, payload_valid, pkt_ok, pkt_err}, 8'h00);
      check_val("s6b_rst_status", status, 8'h00);
      check_val("s6b_rst_status_valid", {7'b0, status_valid}, 8'h00);
      uart_in = 1'b1;
      repeat (4) @(posedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      expect_ev(EV_PAY, 8'h0A); expect_ev(EV_PAY, 8'h0B); expect_ev(EV_OK, 8'h00);
      send_seq('{8'hAA, 8'h55, 8'h02, 8'h0A, 8'h0B, 8'h03});
      drain("s6b");
      check_val("s6b_status", status, 8'h0A);
      check_val("s6b_status_valid", {7'b0, status_valid}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
